// File: rtl/cla_arb_pkg.sv
// -----------------------------------------------------------------------------
// cla_arb_pkg
//
// Shared definitions for the CLA adder sequencer/arbiter:
//   - cla_arb_state_t : sequencer states (IDLE, SETTLE, RESP)
//   - SAT_MAX/SAT_MIN : signed 8-bit saturation limits
//   - saturate()      : clamps a raw adder sum using the adder's flags
// -----------------------------------------------------------------------------
package cla_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } cla_arb_state_t;

    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;

    // Overflow wins over underflow; the adder never raises both at once.
    function automatic logic [7:0] saturate(input logic [7:0] sum,
                                            input logic       ovf,
                                            input logic       uvf);
        if (ovf)      return SAT_MAX;
        else if (uvf) return SAT_MIN;
        else          return sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin picker. Scans the request vector starting
// at index ptr, wrapping modulo NUM_REQ, and grants the first asserted bit.
//
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  ID_W     highest-priority index for this scan (< NUM_REQ)
//   en      in  1        grant enable; no grant when low
//   gnt     out NUM_REQ  one-hot grant (all zero when nothing granted)
//   gnt_idx out ID_W     encoded grant index (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(ptr) + i) % NUM_REQ;
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cla_add_arbiter.sv
// -----------------------------------------------------------------------------
// cla_add_arbiter
//
// Shares one external 8-bit signed CLA adder among NUM_REQ requesters.
// A round-robin grant in IDLE latches the winner's operands onto the adder
// inputs, the sequencer waits SETTLE_CYCLES for the gate-delay adder to
// settle, then captures sum/flags and offers them on a valid/ready response
// channel tagged with the requester index.
//
// Build option: define CLA_ARB_SAT_EN to saturate rsp_sum to 8'h7F / 8'h80
// on overflow / underflow; otherwise rsp_sum is the raw wrap-around sum.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid / req_ready per-requester request handshake (ready one-hot/zero)
//   req_a / req_b         per-requester signed operands
//   add_a / add_b         registered operands to the adder
//   add_sum/add_ovf/uvf   adder result and flags
//   rsp_valid / rsp_ready response handshake
//   rsp_id                requester index of the response
//   rsp_sum/ovf/uvf       captured result and flags
// -----------------------------------------------------------------------------
module cla_add_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][7:0] req_a,
    input  logic [NUM_REQ-1:0][7:0] req_b,
    output logic [7:0]              add_a,
    output logic [7:0]              add_b,
    input  logic [7:0]              add_sum,
    input  logic                    add_ovf,
    input  logic                    add_uvf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [7:0]              rsp_sum,
    output logic                    rsp_ovf,
    output logic                    rsp_uvf
);

    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]   PTR_LAST = ID_W'(NUM_REQ - 1);

    cla_arb_state_t     state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               arb_en;
    logic [7:0]         cap_sum;

    // Gating with rst_n keeps req_ready low while reset is held, even though
    // the state register already reads IDLE.
    assign arb_en = rst_n && (state == IDLE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

`ifdef CLA_ARB_SAT_EN
    assign cap_sum = saturate(add_sum, add_ovf, add_uvf);
`else
    assign cap_sum = add_sum;
`endif

    // NOTE: all state and output registers use non-blocking assignments so
    // every branch sees the pre-edge values, matching real flip-flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_uvf   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // gnt is only non-zero when the granted req_valid is set,
                    // so any grant here is an accepted request.
                    if (|gnt) begin
                        add_a  <= req_a[gnt_idx];
                        add_b  <= req_b[gnt_idx];
                        rsp_id <= gnt_idx;
                        rr_ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + ID_W'(1);
                        cnt    <= '0;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        rsp_sum   <= cap_sum;
                        rsp_ovf   <= add_ovf;
                        rsp_uvf   <= add_uvf;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cla_add_arbiter
//
// Self-checking bench for cla_add_arbiter (NUM_REQ=4, SETTLE_CYCLES=2).
// A behavioural stand-in for the CLA adder drives add_sum/add_ovf/add_uvf.
// A transaction-level reference model (round-robin scan, latency countdown,
// integer arithmetic for the signed sum) predicts every output each cycle.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_cla_add_arbiter;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int IW = $clog2(N);

`ifdef CLA_ARB_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'h7F;
    localparam logic [7:0] UVF_SUM = 8'h80;
`else
    localparam logic [7:0] OVF_SUM = 8'h80;
    localparam logic [7:0] UVF_SUM = 8'h7F;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][7:0]   req_a;
    logic [N-1:0][7:0]   req_b;
    logic [7:0]          add_a, add_b, add_sum;
    logic                add_ovf, add_uvf;
    logic                rsp_valid, rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [7:0]          rsp_sum;
    logic                rsp_ovf, rsp_uvf;

    always #5 clk = ~clk;

    // Stand-in for the shared adder.
    assign add_sum = add_a + add_b;
    assign add_ovf = ~add_a[7] & ~add_b[7] &  add_sum[7];
    assign add_uvf =  add_a[7] &  add_b[7] & ~add_sum[7];

    cla_add_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_ovf   (add_ovf),
        .add_uvf   (add_uvf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .rsp_uvf   (rsp_uvf)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit         m_idle = 1'b1;
    bit         m_pend = 1'b0;
    int         m_wait = 0;
    int         m_ptr  = 0;
    int         m_id   = 0;
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    logic [7:0] m_sum  = '0;
    bit         m_ovf  = 1'b0;
    bit         m_uvf  = 1'b0;
    int         gnt_log[$];
    int         last_gnt = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 8'h7F;
            1:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // One clock: compare outputs against the model, then advance the model
    // by the edge that is about to happen.
    task automatic tick();
        int           g;
        logic [N-1:0] exp_rdy;
        int           sa, sb, s;
        #1;
        g       = m_idle ? rr_pick(req_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_pend);
        if (m_pend) begin
            check("rsp_id",  rsp_id,  m_id);
            check("rsp_sum", rsp_sum, m_sum);
            check("rsp_ovf", rsp_ovf, m_ovf);
            check("rsp_uvf", rsp_uvf, m_uvf);
        end
        check("add_a", add_a, m_a);
        check("add_b", add_b, m_b);
        last_gnt = -1;
        if (g >= 0) begin
            sa     = int'($signed(req_a[g]));
            sb     = int'($signed(req_b[g]));
            s      = sa + sb;
            m_a    = req_a[g];
            m_b    = req_b[g];
            m_id   = g;
            m_ovf  = (s > 127);
            m_uvf  = (s < -128);
            m_sum  = s[7:0];
`ifdef CLA_ARB_SAT_EN
            if (m_ovf) m_sum = 8'h7F;
            if (m_uvf) m_sum = 8'h80;
`endif
            m_idle   = 1'b0;
            m_wait   = S;
            m_ptr    = (g + 1) % N;
            last_gnt = g;
            gnt_log.push_back(g);
        end else if (!m_idle && !m_pend) begin
            m_wait--;
            if (m_wait == 0) m_pend = 1'b1;
        end else if (m_pend && rsp_ready) begin
            m_pend = 1'b0;
            m_idle = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && !m_idle; c++) tick();
        check("drain_bound", m_idle, 1'b1);
    endtask

    task automatic single_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_sum, input logic exp_ovf, input logic exp_uvf);
        int cyc;
        drain();
        req_a[0]  = a;
        req_b[0]  = b;
        req_valid = 4'b0001;
        tick();
        check({tag, "_gnt"}, last_gnt, 0);
        req_valid = '0;
        cyc = 0;
        while (!m_pend && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, S);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_sum"},   rsp_sum,   exp_sum);
        check({tag, "_id"},    rsp_id,    0);
        check({tag, "_ovf"},   rsp_ovf,   exp_ovf);
        check({tag, "_uvf"},   rsp_uvf,   exp_uvf);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int         exp1[4];
        int         exp2[4];
        logic [7:0] hold_sum;
        logic [IW-1:0] hold_id;

        exp1 = '{0, 1, 2, 3};
        exp2 = '{1, 3, 1, 3};

        // Reset with every requester asserting: no grant may leak out.
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 8'(i + 1);
            req_b[i] = 8'(i * 16);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_add_a",     add_a,     '0);
        check("rst_add_b",     add_b,     '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id",    rsp_id,    '0);
        check("rst_rsp_sum",   rsp_sum,   '0);
        check("rst_rsp_flags", {rsp_ovf, rsp_uvf}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: all four valid right after reset.
        gnt_log.delete();
        for (int c = 0; c < 100 && gnt_log.size() < 4; c++) begin
            tick();
            if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
        end
        check("fair1_count", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size() && i < 4; i++) check("fair1_order", gnt_log[i], exp1[i]);

        // Fairness: requesters 1 and 3 valid continuously.
        gnt_log.delete();
        req_valid = 4'b1010;
        for (int c = 0; c < 100 && gnt_log.size() < 4; c++) tick();
        req_valid = '0;
        check("fair2_count", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size() && i < 4; i++) check("fair2_order", gnt_log[i], exp2[i]);

        // Arithmetic corners.
        single_op("single", 8'h05, 8'h03, 8'h08,  1'b0, 1'b0);
        single_op("ovf",    8'h7F, 8'h01, OVF_SUM, 1'b1, 1'b0);
        single_op("uvf",    8'h80, 8'hFF, UVF_SUM, 1'b0, 1'b1);

        // Backpressure: response held for 5 cycles while requester 1 waits.
        drain();
        req_a[2]  = 8'h10;
        req_b[2]  = 8'h20;
        req_valid = 4'b0100;
        tick();
        check("bp_gnt", last_gnt, 2);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20 && !m_pend; c++) tick();
        check("bp_pend", rsp_valid, 1'b1);
        hold_sum = rsp_sum;
        hold_id  = rsp_id;
        for (int c = 0; c < 5; c++) tick();
        check("bp_sum_stable", rsp_sum, hold_sum);
        check("bp_id_stable",  rsp_id,  hold_id);
        check("bp_sum_value",  rsp_sum, 8'h30);
        rsp_ready = 1'b1;
        tick();
        tick();
        check("bp_next_accept", last_gnt, 1);
        req_valid = '0;
        drain();

        // Reset while SETTLE is in progress.
        req_a[1]  = 8'h11;
        req_b[1]  = 8'h22;
        req_valid = 4'b0010;
        tick();
        check("rs_gnt", last_gnt, 1);
        req_valid = '0;
        tick();
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("rs_req_ready", req_ready, '0);
        check("rs_add_a",     add_a,     '0);
        check("rs_add_b",     add_b,     '0);
        check("rs_rsp_valid", rsp_valid, 1'b0);
        check("rs_rsp_id",    rsp_id,    '0);
        check("rs_rsp_sum",   rsp_sum,   '0);
        check("rs_flags",     {rsp_ovf, rsp_uvf}, 2'b00);
        m_idle = 1'b1;
        m_pend = 1'b0;
        m_ptr  = 0;
        m_a    = '0;
        m_b    = '0;
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        req_valid = '1;
        tick();
        check("rs_first_gnt", last_gnt, 0);
        req_valid = '0;
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i]     = rand_op();
                    req_b[i]     = rand_op();
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
        end
        req_valid = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_add_arbiter.md
# cla_add_arbiter

Sequencer and round-robin arbiter that shares one instance of the 8-bit signed CLA adder with overflow/underflow detection among `NUM_REQ` requesters. It registers the granted operands onto the adder inputs and waits a programmable number of cycles for the gate-delay adder to settle. It then captures sum and flags and returns them on a valid/ready response channel tagged with the requester index. It sits between the requesting engines and the adder, and is the only block that drives the adder's inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters. Legal range 2..16.
- `SETTLE_CYCLES`, 2: cycles the adder inputs are held before the result is captured. Minimum 1.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index. Derived; not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester.
- `req_ready`  out  `NUM_REQ`  grant/accept, one-hot or zero.
- `req_a`  in  `NUM_REQ`×8  signed operand A per requester.
- `req_b`  in  `NUM_REQ`×8  signed operand B per requester.
- `add_a`  out  8  registered operand A to the adder.
- `add_b`  out  8  registered operand B to the adder.
- `add_sum`  in  8  adder sum.
- `add_ovf`  in  1  adder overflow flag.
- `add_uvf`  in  1  adder underflow flag.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  `ID_W`  index of the requester the result belongs to.
- `rsp_sum`  out  8  result (saturated or raw; see Configuration).
- `rsp_ovf`  out  1  captured overflow flag.
- `rsp_uvf`  out  1  captured underflow flag.

## Operation
- FSM states `IDLE`, `SETTLE`, `RESP`. Reset state is `IDLE`.
- `IDLE`:
  - The round-robin arbiter selects the first asserted `req_valid`, starting from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is 1 for the granted index only, combinationally. A request is accepted when `req_valid[g]` and `req_ready[g]` are both 1.
  - On accept: `add_a`/`add_b` ← `req_a[g]`/`req_b[g]`; `rsp_id` ← g; `rr_ptr` ← (g+1) mod `NUM_REQ`; settle counter ← 0; go to `SETTLE`.
  - No valid requests: remain in `IDLE`.
- `SETTLE`:
  - `req_ready` is all 0.
  - The counter increments each cycle.
  - When the counter equals `SETTLE_CYCLES`-1: capture `add_sum`/`add_ovf`/`add_uvf` into the `rsp_*` registers, set `rsp_valid`=1, go to `RESP`.
- `RESP`:
  - `req_ready` is all 0. All `rsp_*` outputs are held stable.
  - On `rsp_valid`&`rsp_ready`: clear `rsp_valid`, go to `IDLE`.
- `add_a`/`add_b` remain stable from accept until the next accept. They are never changed while in `SETTLE` or `RESP`.
- Requesters hold `req_valid` and their operands until accepted. Deasserting `req_valid` before acceptance withdraws the request; this is legal.
- Reset values: `add_a`, `add_b`, `rsp_sum`, `rsp_id` = 0; `rsp_valid`, `rsp_ovf`, `rsp_uvf` = 0; `req_ready` = 0 (FSM is forced to `IDLE` with no grant while `rst_n` is low); `rr_ptr` = 0.
- Reset asserted mid-operation: the transaction in flight is abandoned and no response is produced. After reset is released, arbitration restarts with requester 0 at highest priority.

## Timing
- Accept edge E. `rsp_valid` rises at edge E+`SETTLE_CYCLES`.
- The response handshake completes at edge R. The earliest next accept is edge R+1 (one `IDLE` cycle).
- Maximum throughput: one transaction per `SETTLE_CYCLES`+2 cycles.
- `req_ready` is a combinational function of `req_valid`, `rr_ptr` and state. `req_ready` has no combinational dependency on `rsp_ready`.
- Simultaneous requests: exactly one grant per `IDLE` cycle. Every requester is served within `NUM_REQ` transactions (no starvation).
- `rr_ptr` wraps from `NUM_REQ`-1 to 0.

## Configuration
- Macro `CLA_ARB_SAT_EN`.
- Defined: `rsp_sum` = 8'h7F when the captured `add_ovf`=1, 8'h80 when `add_uvf`=1, otherwise `add_sum`.
- Not defined: `rsp_sum` = `add_sum` (raw wrap-around result).
- `rsp_ovf`/`rsp_uvf` report the adder flags in both builds.

## Structure
- Package `cla_arb_pkg`:
  - state enum `cla_arb_state_t` (`IDLE`, `SETTLE`, `RESP`);
  - constants `SAT_MAX`=8'h7F and `SAT_MIN`=8'h80.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs `req`, `ptr`, `en`;
  - outputs one-hot `gnt` and encoded `gnt_idx`.
- The adder itself is instantiated by the parent, not inside this block.

## Test plan
- Single request: `NUM_REQ`=4, `SETTLE_CYCLES`=2; requester 0 sends a=0x05, b=0x03 → `rsp_valid` at accept+2 edges; `rsp_sum`=0x08, `rsp_id`=0, both flags 0.
- Overflow: a=0x7F, b=0x01 → `rsp_ovf`=1; `rsp_sum`=0x7F with `CLA_ARB_SAT_EN`, 0x80 without.
- Underflow: a=0x80, b=0xFF → `rsp_uvf`=1; `rsp_sum`=0x80 with `CLA_ARB_SAT_EN`, 0x7F without.
- Fairness:
  - All four requesters valid right after reset → grant order 0,1,2,3.
  - Then only requesters 1 and 3 valid continuously → grants alternate 1,3,1,3.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in `RESP` → `rsp_*` stable, `req_ready`=0; accept occurs 1 cycle after the response handshake.
- Reset during `SETTLE`: drive `rst_n` low → all outputs 0 immediately, no response ever appears; first grant after release goes to requester 0.
